// File: rtl/urv_imem_prefetch_if.sv
// Fetch-side and Wishbone-side signals of the instruction prefetch buffer.
// The slave modport is the buffer's view; master is the fetch stage plus bus slave.
interface urv_imem_prefetch_if;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        im_flush_i;
    logic        im_err_o;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport slave (
        input  im_addr_i, im_flush_i, wb_dat_i, wb_ack_i, wb_err_i,
        output im_data_o, im_valid_o, im_err_o, wb_adr_o, wb_cyc_o, wb_stb_o
    );

    modport master (
        output im_addr_i, im_flush_i, wb_dat_i, wb_ack_i, wb_err_i,
        input  im_data_o, im_valid_o, im_err_o, wb_adr_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/urv_imem_prefetch.sv
// Instruction-memory responder: two-entry buffer (current word + sequential
// prefetch) in front of a classic Wishbone read master.
module urv_imem_prefetch #(
    parameter bit          PREFETCH = 1'b1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    urv_imem_prefetch_if.slave bus
);
    localparam int unsigned TAG_W = 30;
    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH} state_t;

    state_t             state_q, state_d;
    logic               cur_v_q, cur_v_d, pre_v_q, pre_v_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d, pre_tag_q, pre_tag_d;
    logic [31:0]        cur_data_q, cur_data_d, pre_data_q, pre_data_d;
    logic [31:0]        data_q, data_d, adr_q, adr_d;
    logic               valid_q, valid_d, err_q, err_d, cyc_q, cyc_d;
    logic               drop_q, drop_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [TAG_W-1:0]   tag_a, req_tag, pf_tag;
    logic               hit_cur, hit_pre, flush;
    logic               bus_ack, bus_err, bus_tmo, req_done, keep, fwd, cur_wr;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^bus.im_addr_i[1:0];

    assign tag_a    = bus.im_addr_i[31:2];
    assign req_tag  = adr_q[31:2];
    assign pf_tag   = cur_tag_q + TAG_W'(1);
    assign flush    = bus.im_flush_i;
    assign hit_cur  = cur_v_q && (cur_tag_q == tag_a);
    assign hit_pre  = pre_v_q && (pre_tag_q == tag_a);
    assign bus_ack  = cyc_q && bus.wb_ack_i;
    assign bus_err  = cyc_q && !bus.wb_ack_i && bus.wb_err_i;
    assign bus_tmo  = cyc_q && !bus.wb_ack_i && !bus.wb_err_i && (tmo_q == TMO_LAST);
    assign req_done = bus_ack || bus_err || bus_tmo;
    // Read data survives only if no flush hit the request at any point.
    assign keep     = bus_ack && !drop_q && !flush;
    assign fwd      = keep && (tag_a == req_tag);
    assign cur_wr   = keep && ((state_q == S_DEMAND) || fwd);

    // Next-state, entry update and output logic.
    always_comb begin
        state_d    = state_q;
        cur_v_d    = cur_v_q;
        cur_tag_d  = cur_tag_q;
        cur_data_d = cur_data_q;
        pre_v_d    = pre_v_q;
        pre_tag_d  = pre_tag_q;
        pre_data_d = pre_data_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        adr_d      = adr_q;
        cyc_d      = cyc_q;
        drop_d     = drop_q;
        tmo_d      = tmo_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (fwd) begin
            valid_d = 1'b1;
            data_d  = bus.wb_dat_i;
        end else if (hit_cur) begin
            valid_d = 1'b1;
            data_d  = cur_data_q;
        end else if (hit_pre) begin
            valid_d = 1'b1;
            data_d  = pre_data_q;
        end

        // Promote PRE on a hit unless CUR is being filled from the bus.
        if (!flush && !fwd && !hit_cur && hit_pre && !cur_wr) begin
            cur_v_d    = 1'b1;
            cur_tag_d  = pre_tag_q;
            cur_data_d = pre_data_q;
            pre_v_d    = 1'b0;
        end

        if (cur_wr) begin
            cur_v_d    = 1'b1;
            cur_tag_d  = req_tag;
            cur_data_d = bus.wb_dat_i;
        end else if (keep) begin
            pre_v_d    = 1'b1;
            pre_tag_d  = req_tag;
            pre_data_d = bus.wb_dat_i;
        end

        if (flush) begin
            cur_v_d = 1'b0;
            pre_v_d = 1'b0;
        end

        if (req_done) begin
            drop_d = 1'b0;
        end else if (flush && cyc_q) begin
            drop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (!flush && !hit_cur && !hit_pre) begin
                    state_d = S_DEMAND;
                    adr_d   = {tag_a, 2'b00};
                    cyc_d   = 1'b1;
                end else if (!flush && PREFETCH && cur_v_q &&
                             !(pre_v_q && (pre_tag_q == pf_tag))) begin
                    state_d = S_PREFETCH;
                    adr_d   = {pf_tag, 2'b00};
                    cyc_d   = 1'b1;
                end
            end
            S_DEMAND, S_PREFETCH: begin
                if (req_done) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    tmo_d   = '0;
                    err_d   = (bus_err || bus_tmo) && (state_q == S_DEMAND);
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cur_v_q    <= 1'b0;
            cur_tag_q  <= '0;
            cur_data_q <= '0;
            pre_v_q    <= 1'b0;
            pre_tag_q  <= '0;
            pre_data_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            cyc_q      <= 1'b0;
            drop_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_v_q    <= cur_v_d;
            cur_tag_q  <= cur_tag_d;
            cur_data_q <= cur_data_d;
            pre_v_q    <= pre_v_d;
            pre_tag_q  <= pre_tag_d;
            pre_data_q <= pre_data_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            adr_q      <= adr_d;
            cyc_q      <= cyc_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.im_data_o  = data_q;
    assign bus.im_valid_o = valid_q;
    assign bus.im_err_o   = err_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
endmodule

// File: tb/tb_urv_imem_prefetch.sv
// Directed per-cycle vector bench for urv_imem_prefetch, plus timeout/error
// and reset-during-request sequences.
module tb_urv_imem_prefetch;
    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    urv_imem_prefetch_if bus();

    urv_imem_prefetch #(.PREFETCH(1'b1), .TIMEOUT(255)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic [31:0] a, input logic f, input logic k,
                               input logic e, input logic [31:0] d, input logic ev,
                               input logic [31:0] ed, input logic ec,
                               input logic [31:0] ea, input logic ee);
        vec_t r;
        r.addr = a; r.flush = f; r.ack = k; r.err = e; r.dat = d;
        r.e_valid = ev; r.e_data = ed; r.e_cyc = ec; r.e_adr = ea; r.e_err = ee;
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic f, input logic k,
                         input logic e, input logic [31:0] d);
        bus.im_addr_i  = a;
        bus.im_flush_i = f;
        bus.wb_ack_i   = k;
        bus.wb_err_i   = e;
        bus.wb_dat_i   = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int vseen;
        bit done;

        //      addr          fl    ack   err   dat            valid data          cyc   adr           err
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 32'h0000_0013, 1'b0, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0013, 1'b1, 32'h0000_0004, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_00A4, 1'b1, 32'h0000_0013, 1'b0, 32'h0000_0004, 1'b0));
        vq.push_back(v(32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00A4, 1'b0, 32'h0000_0004, 1'b0));
        vq.push_back(v(32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00A4, 1'b1, 32'h0000_0008, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00A4, 1'b1, 32'h0000_0008, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_00A8, 1'b0, 32'h0000_00A4, 1'b0, 32'h0000_0008, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00A4, 1'b1, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_00B0, 1'b1, 32'h0000_00B0, 1'b0, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b0, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b1, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b1, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0000_00B0, 1'b0, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b1, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b1, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0000_00C0, 1'b0, 32'h0000_00B0, 1'b0, 32'h0000_0100, 1'b0));
        vq.push_back(v(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00B0, 1'b1, 32'h0000_0200, 1'b0));
        vq.push_back(v(32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0000_00C2, 1'b1, 32'h0000_00C2, 1'b0, 32'h0000_0200, 1'b0));
        vq.push_back(v(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00C2, 1'b1, 32'h0000_0204, 1'b0));
        vq.push_back(v(32'h0000_0204, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00C2, 1'b1, 32'h0000_0204, 1'b0));
        vq.push_back(v(32'h0000_0204, 1'b0, 1'b1, 1'b0, 32'h0000_00E4, 1'b1, 32'h0000_00E4, 1'b0, 32'h0000_0204, 1'b0));
        vq.push_back(v(32'h0000_0204, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00E4, 1'b1, 32'h0000_0208, 1'b0));
        vq.push_back(v(32'h0000_0204, 1'b0, 1'b1, 1'b0, 32'h0000_00F8, 1'b1, 32'h0000_00E4, 1'b0, 32'h0000_0208, 1'b0));
        vq.push_back(v(32'h0000_0208, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00F8, 1'b0, 32'h0000_0208, 1'b0));
        vq.push_back(v(32'h0000_0208, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00F8, 1'b1, 32'h0000_020C, 1'b0));
        vq.push_back(v(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_00F8, 1'b0, 32'h0000_020C, 1'b0));
        vq.push_back(v(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00F8, 1'b1, 32'hFFFF_FFFC, 1'b0));
        vq.push_back(v(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 1'b1, 32'h0000_0077, 1'b0, 32'hFFFF_FFFC, 1'b0));
        vq.push_back(v(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0077, 1'b1, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0000_0099, 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0099, 1'b0, 32'h0000_0000, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0099, 1'b1, 32'h0000_0004, 1'b0));
        vq.push_back(v(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0099, 1'b0, 32'h0000_0004, 1'b0));
        vq.push_back(v(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0099, 1'b1, 32'h0000_0300, 1'b0));
        vq.push_back(v(32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0000_0099, 1'b0, 32'h0000_0300, 1'b1));
        vq.push_back(v(32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0099, 1'b1, 32'h0000_0300, 1'b0));
        vq.push_back(v(32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0000_0030, 1'b1, 32'h0000_0030, 1'b0, 32'h0000_0300, 1'b0));

        do_reset();
        chk("rst_valid", 0, 32'(bus.im_valid_o), 32'h0);
        chk("rst_data",  0, bus.im_data_o, 32'h0);
        chk("rst_err",   0, 32'(bus.im_err_o), 32'h0);
        chk("rst_cyc",   0, 32'(bus.wb_cyc_o), 32'h0);
        chk("rst_stb",   0, 32'(bus.wb_stb_o), 32'h0);
        chk("rst_adr",   0, bus.wb_adr_o, 32'h0);

        foreach (vq[i]) begin
            drive(vq[i].addr, vq[i].flush, vq[i].ack, vq[i].err, vq[i].dat);
            step();
            chk("valid", i, 32'(bus.im_valid_o), 32'(vq[i].e_valid));
            chk("data",  i, bus.im_data_o, vq[i].e_data);
            chk("cyc",   i, 32'(bus.wb_cyc_o), 32'(vq[i].e_cyc));
            chk("stb",   i, 32'(bus.wb_stb_o), 32'(vq[i].e_cyc));
            chk("adr",   i, bus.wb_adr_o, vq[i].e_adr);
            chk("err",   i, 32'(bus.im_err_o), 32'(vq[i].e_err));
        end

        // Unanswered demand: bus cycle must be abandoned after TIMEOUT cycles.
        do_reset();
        drive(32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'h0);
        hi = 0;
        vseen = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (bus.im_valid_o) vseen++;
            if (bus.wb_cyc_o) begin
                hi++;
            end else if (hi > 0) begin
                chk("tmo_len", i, 32'(hi), 32'd255);
                chk("tmo_errpulse", i, 32'(bus.im_err_o), 32'h1);
                done = 1'b1;
            end
        end
        chk("tmo_bound", 0, 32'(done), 32'h1);
        step();
        chk("retry_err_low", 0, 32'(bus.im_err_o), 32'h0);
        chk("retry_cyc", 0, 32'(bus.wb_cyc_o), 32'h1);
        chk("retry_adr", 0, bus.wb_adr_o, 32'h0000_0400);
        bus.wb_err_i = 1'b1;
        step();
        bus.wb_err_i = 1'b0;
        chk("buserr_cyc", 0, 32'(bus.wb_cyc_o), 32'h0);
        chk("buserr_pulse", 0, 32'(bus.im_err_o), 32'h1);
        chk("buserr_valid", 0, 32'(bus.im_valid_o), 32'h0);
        step();
        chk("buserr_pulse_end", 0, 32'(bus.im_err_o), 32'h0);
        chk("buserr_retry_cyc", 0, 32'(bus.wb_cyc_o), 32'h1);
        chk("tmo_never_valid", 0, 32'(vseen), 32'h0);

        // Reset while a demand is outstanding; a late ack must be ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_cyc", 0, 32'(bus.wb_cyc_o), 32'h0);
        chk("midrst_stb", 0, 32'(bus.wb_stb_o), 32'h0);
        chk("midrst_adr", 0, bus.wb_adr_o, 32'h0);
        chk("midrst_valid", 0, 32'(bus.im_valid_o), 32'h0);
        drive(32'h0000_0400, 1'b0, 1'b1, 1'b0, 32'h0000_0055);
        step();
        bus.wb_ack_i = 1'b0;
        chk("late_ack_valid", 0, 32'(bus.im_valid_o), 32'h0);
        chk("late_ack_data", 0, bus.im_data_o, 32'h0);
        chk("late_ack_newreq", 0, 32'(bus.wb_cyc_o), 32'h1);
        step();
        chk("late_ack_valid2", 1, 32'(bus.im_valid_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
